// File: rtl/ps2_key_fifo_rx.sv
// ps2_key_fifo_rx: oversampled PS/2 keyboard receiver with make/break/extended decode and FWFT event FIFO
// Ports: clk, rst_n (async, active-low); ps2_clk/ps2_data raw pins;
//   evt_valid/evt_ready pop handshake with head fields evt_code, evt_ext, evt_break, evt_ascii;
//   fifo_count occupancy; frame_err and overflow one-cycle pulses.
// Optional: define PS2_ASCII_EN to decode evt_ascii from the head entry (tied to 0 otherwise).
module ps2_key_fifo_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [7:0]                    evt_ascii,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, data, fclk, fall, flip;
    logic [FW-1:0]          filt_cnt;
    state_t                 state, state_nx;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_ok, tmo, err, byte_ok, rx_v, push, pop, full, wr;
    logic [TW-1:0]          to_cnt;
    logic                   ext_f, brk_f;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [9:0]             mem [FIFO_DEPTH];
    logic [9:0]             head;
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign data  = dat_sync[SYNC_STAGES-1];
    // fclk follows clk_s only after FILT_CYC consecutive differing samples
    assign flip  = (clk_s != fclk) && (filt_cnt == FW'(FILT_CYC - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            fclk     <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            filt_cnt <= (clk_s == fclk || flip) ? '0 : filt_cnt + FW'(1);
            fclk     <= flip ? clk_s : fclk;
            fall     <= flip & ~clk_s;
        end
    end
    assign tmo = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = tmo ? IDLE :
                   !fall ? state :
                   state == IDLE ? (data ? IDLE : DATA) :
                   state == DATA ? (bit_cnt == 3'd7 ? PARITY : DATA) :
                   state == PARITY ? STOP : IDLE;
    end
    always_comb begin
        err     = tmo | (fall & (((state == IDLE) & data) | ((state == STOP) & ~(data & par_ok))));
        byte_ok = ~tmo & fall & (state == STOP) & data & par_ok;
    end
    // shreg stays untouched from the stop bit until the next frame's first data bit,
    // so the decoder can read it on the cycle after byte_ok without a copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_ok    <= 1'b0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
            rx_v      <= 1'b0;
        end else begin
            to_cnt    <= (fall || state == IDLE) ? '0 : to_cnt + TW'(1);
            frame_err <= err;
            rx_v      <= byte_ok;
            if (fall && !tmo) begin
                bit_cnt <= (state == DATA) ? bit_cnt + 3'd1 : 3'd0;
                if (state == DATA) shreg <= {data, shreg[7:1]};
                if (state == PARITY) par_ok <= (^shreg) ^ data;
            end
        end
    end
    assign push = rx_v & ~frame_err & (shreg != 8'hE0) & (shreg != 8'hF0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (frame_err || push) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (rx_v) begin
            ext_f <= ext_f | (shreg == 8'hE0);
            brk_f <= brk_f | (shreg == 8'hF0);
        end
    end
    assign full      = fifo_count == CW'(FIFO_DEPTH);
    assign evt_valid = fifo_count != '0;
    assign pop       = evt_valid & evt_ready;
    assign wr        = push & (~full | pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(wr);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + CW'(wr) - CW'(pop);
            overflow   <= push & full & ~pop;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {ext_f, brk_f, shreg};
    end
    assign head = mem[rd_ptr];
    assign {evt_ext, evt_break, evt_code} = evt_valid ? head : 10'd0;
`ifdef PS2_ASCII_EN
    function automatic logic [7:0] to_ascii(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43; 8'h23: return 8'h44;
            8'h24: return 8'h45; 8'h2B: return 8'h46; 8'h34: return 8'h47; 8'h33: return 8'h48;
            8'h43: return 8'h49; 8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
            8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F; 8'h4D: return 8'h50;
            8'h15: return 8'h51; 8'h2D: return 8'h52; 8'h1B: return 8'h53; 8'h2C: return 8'h54;
            8'h3C: return 8'h55; 8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
            8'h35: return 8'h59; 8'h1A: return 8'h5A;
            8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
            8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
            8'h3E: return 8'h38; 8'h46: return 8'h39;
            8'h29: return 8'h20; 8'h5A: return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction
    assign evt_ascii = (evt_valid && !evt_ext) ? to_ascii(evt_code) : 8'h00;
`else
    assign evt_ascii = 8'h00;
`endif
endmodule

// File: doc/ps2_key_fifo_rx.md
# ps2_key_fifo_rx

Synchronous, oversampled PS/2 keyboard receiver that replaces direct `ps2_clk`-edge clocking with system-clock sampling. It validates each 11-bit frame, decodes the E0/F0 prefixes into make/break/extended key events, and buffers those events in a parametrised first-word-fall-through FIFO with a valid/ready pop interface. It sits between the board PS/2 pins and the CPU/peripheral bus, or a display/debug path.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; power of 2, range 2–64.
- `SYNC_STAGES`, 2: synchroniser flops on `ps2_clk` and `ps2_data`; minimum 2.
- `FILT_CYC`, 8: consecutive equal samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYC`, 100000: idle cycles mid-frame before the frame is aborted (2 ms at 50 MHz).
- `clk` input 1: system clock, 50 MHz nominal.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous.
- `evt_valid` output 1: FIFO head holds an event.
- `evt_ready` input 1: consumer pops the head when `evt_valid & evt_ready`.
- `evt_code` output 8: scan code of the head event.
- `evt_ext` output 1: the head event was preceded by E0.
- `evt_break` output 1: the head event was preceded by F0 (key release).
- `evt_ascii` output 8: ASCII of the head event (see Configuration).
- `fifo_count` output $clog2(FIFO_DEPTH)+1: occupied entries.
- `frame_err` output 1: one-cycle pulse on a start, parity, stop or timeout error.
- `overflow` output 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Front end:** both pins pass through `SYNC_STAGES` flops. The filtered clock `fclk` changes only after `FILT_CYC` consecutive samples differ from its current value. `fclk` resets to 1. A falling edge of `fclk` generates a one-cycle `fall` strobe. Data is sampled from the synchronised `ps2_data` on `fall`.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP. All transitions occur on `fall`.
  - IDLE: data=0 → DATA, with bit counter cleared. Data=1 → stay in IDLE and pulse `frame_err`.
  - DATA: 8 bits, LSB first, shifted into a byte register. Transition to PARITY after bit 7.
  - PARITY: store `par_ok = (^byte) ^ data`, which is 1 for odd parity. Transition to STOP.
  - STOP: if data=1 and `par_ok`, the byte goes to the decoder. Otherwise pulse `frame_err`. Always → IDLE.
- **Timeout:** a cycle counter resets on every `fall` and counts in non-IDLE states. When it reaches `TIMEOUT_CYC`, the FSM goes to IDLE, pulses `frame_err`, and clears the decoder flags.
- **Decoder:**
  - Byte E0 sets `ext_f`.
  - Byte F0 sets `brk_f`.
  - Any other byte, including AA and FA, pushes `{ext_f, brk_f, byte}` and clears both flags.
  - A `frame_err` pulse also clears both flags.
- **FIFO:**
  - Push while `fifo_count == FIFO_DEPTH` and no pop in the same cycle: the event is dropped and `overflow` pulses.
  - Simultaneous push and pop when full: both are performed, the count is unchanged, and there is no overflow.
  - Pop while empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset values:** `evt_valid`=0, `evt_code`=0, `evt_ext`=0, `evt_break`=0, `evt_ascii`=0, `fifo_count`=0, `frame_err`=0, `overflow`=0. The FSM is in IDLE, flags are clear, and `fclk`=1. Asserting `rst_n` mid-frame discards the partial frame and the FIFO contents.

## Timing
- A pin falling edge produces `fall` `SYNC_STAGES + FILT_CYC` cycles later, ±1 cycle.
- Push latency: the event is pushed on the cycle after the stop-bit `fall`. `evt_valid` rises one cycle after the push.
- The head outputs are stable while `evt_valid & ~evt_ready`. After a pop, the next entry appears on the following cycle.
- Glitches on `ps2_clk` shorter than `FILT_CYC` cycles produce no `fall`.

## Configuration
- `PS2_ASCII_EN` defined: `evt_ascii` is combinationally decoded from the head entry. The same mapping applies to make and break events.
  - Letters map to uppercase: 1C→41 'A', 32→42, … 1A→5A.
  - Digits: 45→30, 16→31, 1E→32, 26→33, 25→34, 2E→35, 36→36, 3D→37, 3E→38, 46→39.
  - 29→20 (space) and 5A→0A (Enter).
  - Any extended event, or any other code, gives 00.
- `PS2_ASCII_EN` not defined: `evt_ascii` is tied to 8'h00 and no decode logic is generated.

## Test plan
- **Single make:** a frame carrying 1C with good parity and stop, `evt_ready`=0 → `evt_valid`=1, `evt_code`=1C, `evt_ext`=0, `evt_break`=0, `fifo_count`=1. With `PS2_ASCII_EN`, `evt_ascii`=41.
- **Extended break:** the frame sequence E0, F0, 75 → exactly one event with `evt_code`=75, `evt_ext`=1, `evt_break`=1.
- **Bad parity:** a 1C frame with the parity bit flipped → one `frame_err` pulse and no push. A following good 1D frame pushes 1D with flags clear.
- **Timeout:** a frame stopped after 4 data bits for more than `TIMEOUT_CYC` cycles → one `frame_err` pulse, FSM in IDLE. A next good 29 frame is received correctly.
- **Overflow:** `FIFO_DEPTH`+1 make frames (codes 16, 1E, 26, …) with `evt_ready`=0 → `fifo_count`=`FIFO_DEPTH` and one `overflow` pulse. Popping all entries returns the first `FIFO_DEPTH` codes in order.
- **Glitch and reset:** a 3-cycle low pulse on `ps2_clk` with `FILT_CYC`=8 → no bit accepted. Asserting `rst_n` mid-frame → all outputs return to their reset values.
